// File: rtl/route_distributor_param_pkg.sv
// Shared definitions for the word router: mode codes, legacy destination type,
// statistics width and the word transform applied on enqueue.
package definitions;

  localparam int STAT_W     = 16;
  localparam int MAX_DATA_W = 256;

  typedef logic [4:0] word_destination_t;

  typedef enum logic [2:0] {
    NORMAL       = 3'b000,
    ALL_SET_0    = 3'b100,
    MIDDLE_SET_0 = 3'b101,
    MIDDLE_SET_1 = 3'b110,
    ALL_SET_1    = 3'b111
  } mode_ctrl_t;

  typedef struct packed {
    logic                  illegal;
    logic [MAX_DATA_W-1:0] data;
  } mode_result_t;

  // Operates on a zero-extended word; callers keep the low data_w bits.
  function automatic mode_result_t mode_apply(input logic [2:0] mode,
                                              input logic [MAX_DATA_W-1:0] data,
                                              input int data_w);
    logic [MAX_DATA_W-1:0] mask;
    mode_result_t          res;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      mask[i] = (i >= data_w / 4) && (i < (3 * data_w) / 4);
    end
    res.illegal = 1'b0;
    case (mode)
      NORMAL:       res.data = data;
      ALL_SET_1:    res.data = {MAX_DATA_W{1'b1}};
      ALL_SET_0:    res.data = {MAX_DATA_W{1'b0}};
      MIDDLE_SET_1: res.data = data | mask;
      MIDDLE_SET_0: res.data = data & ~mask;
      default: begin
        res.data    = data;
        res.illegal = 1'b1;
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/route_distributor_param_out_fifo.sv
// Per-lane FIFO with extra-MSB pointers and a registered head word, so the
// lane output is driven straight from a flop.
module route_out_fifo
  import definitions::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              full_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] head_q, head_d;
  logic              push_s, pop_s, empty_s;

  assign empty_s = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push_s  = push_i & ~full_o;
  assign pop_s   = pop_i & ~empty_s;
  assign valid_o = ~empty_s;
  assign data_o  = head_q;

  // Next pointers and next head; a push into a lane that drains to empty
  // this cycle becomes the head directly.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    head_d = head_q;
    if (push_s) begin
      wptr_d = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    if (push_s && (wptr_q == rptr_d)) begin
      head_d = data_i;
    end else begin
      head_d = mem_q[rptr_d[AW-1:0]];
    end
  end

  // Pointer, head and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      head_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      head_q <= head_d;
      if (push_s) begin
        mem_q[wptr_q[AW-1:0]] <= data_i;
      end
    end
  end

endmodule

// File: rtl/route_distributor_param.sv
// Word router: unicast or broadcast into per-lane FIFOs with a mode transform
// on enqueue, drop counting for out-of-range destinations and a mode error flag.
module route_distributor_param
  import definitions::*;
#(
  parameter int NUM_OUT = 32,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 2,
  parameter int DEST_W  = $clog2(NUM_OUT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [DEST_W-1:0]         in_dest,
  input  logic                      in_bcast,
  input  logic [2:0]                mode,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [STAT_W-1:0]         drop_cnt,
  output logic                      mode_err,
  input  logic                      stat_clr
);

  localparam int              DEST_SPAN = 1 << DEST_W;
  localparam logic [DEST_W:0] LANES     = (DEST_W + 1)'(NUM_OUT);

  logic [NUM_OUT-1:0]   full_s;
  logic [NUM_OUT-1:0]   push_s;
  logic [DEST_SPAN-1:0] full_ext_s;
  logic                 in_range_s;
  logic                 hs_s;
  mode_result_t         mode_res_s;
  logic [DATA_W-1:0]    word_s;
  logic [STAT_W-1:0]    drop_cnt_q, drop_cnt_d;
  logic                 mode_err_q, mode_err_d;

  assign in_range_s = ({1'b0, in_dest} < LANES);
  assign full_ext_s = DEST_SPAN'(full_s);
  assign hs_s       = in_valid & in_ready;
  assign mode_res_s = mode_apply(mode, MAX_DATA_W'(in_data), DATA_W);
  assign word_s     = mode_res_s.data[DATA_W-1:0];
  assign drop_cnt   = drop_cnt_q;
  assign mode_err   = mode_err_q;

  if (DATA_W < MAX_DATA_W) begin : g_hi_sink
    logic unused_hi_s;
    assign unused_hi_s = ^mode_res_s.data[MAX_DATA_W-1:DATA_W];
  end

  // Ready looks only at current full flags; a lane popping this cycle still refuses.
  always_comb begin
    in_ready = 1'b0;
    if (in_bcast) begin
      in_ready = ~|full_s;
    end else if (in_range_s) begin
      in_ready = ~full_ext_s[in_dest];
    end else begin
      in_ready = 1'b1;
    end
  end

  // Statistics next state; clear wins over increment and over a new error.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    mode_err_d = mode_err_q;
    if (stat_clr) begin
      drop_cnt_d = '0;
      mode_err_d = 1'b0;
    end else begin
      if (hs_s && !in_bcast && !in_range_s && (drop_cnt_q != {STAT_W{1'b1}})) begin
        drop_cnt_d = drop_cnt_q + STAT_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      if (hs_s && mode_res_s.illegal) begin
        mode_err_d = 1'b1;
      end else begin
        mode_err_d = mode_err_q;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      mode_err_q <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      mode_err_q <= mode_err_d;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
    assign push_s[k] = hs_s & (in_bcast | (in_range_s & (in_dest == DEST_W'(k))));

    route_out_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push_s[k]),
      .pop_i   (out_ready[k]),
      .data_i  (word_s),
      .full_o  (full_s[k]),
      .valid_o (out_valid[k]),
      .data_o  (out_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_route_distributor_param.sv
// Directed bench for route_distributor_param: a default 32-lane instance plus
// a 20-lane instance for out-of-range destination handling.
module tb_route_distributor_param;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         in_valid, in_bcast, stat_clr, in_ready, mode_err;
  logic [15:0]  in_data, drop_cnt;
  logic [4:0]   in_dest;
  logic [2:0]   mode;
  logic [31:0]  out_valid, out_ready;
  logic [511:0] out_data;

  logic         b_in_valid, b_in_bcast, b_stat_clr, b_in_ready, b_mode_err;
  logic [15:0]  b_in_data, b_drop_cnt;
  logic [4:0]   b_in_dest;
  logic [2:0]   b_mode;
  logic [19:0]  b_out_valid, b_out_ready;
  logic [319:0] b_out_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [2:0]  m_tab [5] = '{3'b110, 3'b101, 3'b111, 3'b100, 3'b001};
  logic [15:0] d_tab [5] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h5A5A, 16'hABCD};
  logic [15:0] e_tab [5] = '{16'h1FF4, 16'hF00F, 16'hFFFF, 16'h0000, 16'hABCD};
  logic        r_tab [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  route_distributor_param u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dest(in_dest), .in_bcast(in_bcast), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt), .mode_err(mode_err), .stat_clr(stat_clr)
  );

  route_distributor_param #(.NUM_OUT(20)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_dest(b_in_dest), .in_bcast(b_in_bcast), .mode(b_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .drop_cnt(b_drop_cnt), .mode_err(b_mode_err), .stat_clr(b_stat_clr)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] dest, input logic [15:0] data, input logic [2:0] md);
    in_valid = 1'b1;
    in_bcast = 1'b0;
    in_dest  = dest;
    in_data  = data;
    mode     = md;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [15:0] lane(input int k);
    return out_data[k*16 +: 16];
  endfunction

  initial begin
    in_valid = 1'b0; in_bcast = 1'b0; stat_clr = 1'b0; in_data = '0;
    in_dest = '0; mode = '0; out_ready = '0;
    b_in_valid = 1'b0; b_in_bcast = 1'b0; b_stat_clr = 1'b0; b_in_data = '0;
    b_in_dest = '0; b_mode = '0; b_out_ready = '0;

    step();
    step();
    chk("rst_out_valid", out_valid, 32'h0);
    chk("rst_out_data", out_data, 512'h0);
    chk("rst_drop_cnt", drop_cnt, 16'h0);
    chk("rst_mode_err", mode_err, 1'b0);
    rst_n = 1'b1;
    in_dest = 5'd5;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    send(5'd5, 16'h1234, 3'b000);
    chk("uni_valid", out_valid, 32'h0000_0020);
    chk("uni_data", lane(5), 16'h1234);
    out_ready[5] = 1'b1;
    step();
    out_ready[5] = 1'b0;
    chk("uni_pop", out_valid, 32'h0);

    for (int i = 0; i < 5; i++) begin
      send(5'd0, d_tab[i], m_tab[i]);
      chk("mode_data", lane(0), e_tab[i]);
      chk("mode_err", mode_err, r_tab[i]);
      out_ready[0] = 1'b1;
      step();
      out_ready[0] = 1'b0;
    end

    stat_clr = 1'b1;
    send(5'd1, 16'h1111, 3'b010);
    stat_clr = 1'b0;
    chk("err_clr_prio", mode_err, 1'b0);
    chk("err_clr_data", lane(1), 16'h1111);
    out_ready[1] = 1'b1;
    step();
    out_ready[1] = 1'b0;

    send(5'd3, 16'h0031, 3'b000);
    send(5'd3, 16'h0032, 3'b000);
    in_valid = 1'b1; in_dest = 5'd3; in_data = 16'h0033;
    #1;
    chk("bp_full_ready", in_ready, 1'b0);
    out_ready[3] = 1'b1;
    #1;
    chk("bp_no_passthru", in_ready, 1'b0);
    step();
    chk("bp_head1", lane(3), 16'h0032);
    chk("bp_ready_again", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("bp_head2", lane(3), 16'h0033);
    chk("bp_valid2", out_valid, 32'h0000_0008);
    step();
    out_ready[3] = 1'b0;
    chk("bp_drained", out_valid, 32'h0);

    send(5'd7, 16'h0071, 3'b000);
    send(5'd7, 16'h0072, 3'b000);
    in_valid = 1'b1; in_bcast = 1'b1; in_data = 16'h00AA; in_dest = 5'd0;
    #1;
    chk("bc_blocked", in_ready, 1'b0);
    step();
    chk("bc_no_change", out_valid, 32'h0000_0080);
    out_ready[7] = 1'b1;
    step();
    chk("bc_lane7_head", lane(7), 16'h0072);
    chk("bc_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = '0;
    chk("bc_all_valid", out_valid, 32'hFFFF_FFFF);
    chk("bc_all_data", out_data, {32{16'h00AA}});
    out_ready = '1;
    step();
    out_ready = '0;
    chk("bc_drained", out_valid, 32'h0);

    b_in_valid = 1'b1; b_in_dest = 5'd25; b_in_data = 16'hDEAD;
    #1;
    chk("oor_ready", b_in_ready, 1'b1);
    step();
    step();
    step();
    b_in_valid = 1'b0;
    chk("oor_drop3", b_drop_cnt, 16'd3);
    chk("oor_no_lane", b_out_valid, 20'h0);
    b_in_valid = 1'b1; b_stat_clr = 1'b1;
    step();
    b_in_valid = 1'b0; b_stat_clr = 1'b0;
    chk("oor_clr_prio", b_drop_cnt, 16'd0);
    b_in_valid = 1'b1; b_in_dest = 5'd19; b_in_data = 16'h1919;
    step();
    b_in_valid = 1'b0;
    chk("n20_lane19_valid", b_out_valid, 20'h80000);
    chk("n20_lane19_data", b_out_data[19*16 +: 16], 16'h1919);
    chk("n20_no_drop", b_drop_cnt, 16'd0);

    send(5'd9, 16'h0901, 3'b000);
    send(5'd9, 16'h0902, 3'b000);
    chk("rs_buffered", out_valid, 32'h0000_0200);
    rst_n = 1'b0;
    #1;
    chk("rs_cleared", out_valid, 32'h0);
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; in_dest = 5'd9; in_data = 16'h0903; mode = 3'b000;
    #1;
    chk("rs_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk("rs_valid", out_valid, 32'h0000_0200);
    chk("rs_data", lane(9), 16'h0903);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
